// File: rtl/switch_debounce.sv
// Debounces one raw mechanical switch input: synchroniser, stability counter FSM,
// registered clean level with one-cycle rise/fall pulses and a busy flag.
module switch_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sw_sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  assign sw_sync = sync[SYNC_STAGES-1];

  // Metastability guard: raw sw enters only at sync[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sw};
    end
  end

  // Qualify a candidate level for DEBOUNCE_CYCLES consecutive samples; any
  // disagreeing sample drops straight back to the idle state with no credit kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE_LO;
      cnt      <= '0;
      sw_clean <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      sw_rise <= 1'b0;
      sw_fall <= 1'b0;
      busy    <= (state == WAIT_HI) || (state == WAIT_LO);
      case (state)
        IDLE_LO: begin
          if (sw_sync) begin
            state <= WAIT_HI;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!sw_sync) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE_HI;
            sw_clean <= 1'b1;
            sw_rise  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!sw_sync) begin
            state <= WAIT_LO;
            cnt   <= CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (sw_sync) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE_LO;
            sw_clean <= 1'b0;
            sw_fall  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_switch_debounce;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sw = 1'b0;
  logic sw_clean, sw_rise, sw_fall, busy;
  logic [3:0] obs;
  logic exp_level;
  int checks = 0;
  int errors = 0;

  assign obs = {sw_clean, sw_rise, sw_fall, busy};

  switch_debounce #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .sw_clean(sw_clean),
    .sw_rise(sw_rise),
    .sw_fall(sw_fall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async obs=%b exp=%b", obs, 4'b0000);
    end
    for (int i = 0; i < 10; i++) begin
      sw = ~sw;
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d obs=%b exp=%b", i, obs, 4'b0000);
      end
    end
    sw = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    exp_level = 1'b0;
  endtask

  task automatic test_rise();
    logic [3:0] e_obs;
    sw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      e_obs = {e >= 6, e == 6, 1'b0, (e >= 4) && (e <= 6)};
      checks++;
      if (obs !== e_obs) begin
        errors++;
        $display("FAIL rise edge=%0d obs=%b exp=%b", e, obs, e_obs);
      end
    end
    exp_level = 1'b1;
  endtask

  task automatic test_fall();
    logic [3:0] e_obs;
    sw = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      e_obs = {e < 6, 1'b0, e == 6, (e >= 4) && (e <= 6)};
      checks++;
      if (obs !== e_obs) begin
        errors++;
        $display("FAIL fall edge=%0d obs=%b exp=%b", e, obs, e_obs);
      end
    end
    exp_level = 1'b0;
  endtask

  task automatic test_short_pulse();
    logic [2:0] e_out;
    sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs[3:1] !== 3'b000) begin
        errors++;
        $display("FAIL short_pulse_hi cyc=%0d obs=%b exp=%b", i, obs[3:1], 3'b000);
      end
    end
    sw = 1'b0;
    tick();
    sw = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      e_out = {e >= 6, e == 6, 1'b0};
      checks++;
      if (obs[3:1] !== e_out) begin
        errors++;
        $display("FAIL short_pulse_final edge=%0d obs=%b exp=%b", e, obs[3:1], e_out);
      end
    end
    sw = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (sw_clean !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse_return sw_clean=%b exp=0", sw_clean);
    end
    exp_level = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] e_obs;
    sw = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    checks++;
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL mid_wait obs=%b exp=%b", obs, 4'b0001);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_async obs=%b exp=%b", obs, 4'b0000);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      e_obs = {e >= 6, e == 6, 1'b0, (e >= 4) && (e <= 6)};
      checks++;
      if (obs !== e_obs) begin
        errors++;
        $display("FAIL mid_requal edge=%0d obs=%b exp=%b", e, obs, e_obs);
      end
    end
    exp_level = 1'b1;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== {exp_level, 3'b000}) begin
        errors++;
        $display("FAIL hold cyc=%0d obs=%b exp=%b", i, obs, {exp_level, 3'b000});
      end
    end
  endtask

  task automatic test_bounce(input logic final_level);
    int cycles;
    int run;
    int rises;
    int falls;
    logic prev;
    cycles = 0;
    while (cycles < 200) begin
      run = int'($urandom_range(3, 1));
      sw = ~sw;
      for (int r = 0; r < run && cycles < 200; r++) begin
        tick();
        cycles++;
        checks++;
        if (obs[3:1] !== {exp_level, 2'b00}) begin
          errors++;
          $display("FAIL bounce_mid cyc=%0d obs=%b exp=%b", cycles, obs[3:1], {exp_level, 2'b00});
        end
      end
    end
    sw = final_level;
    rises = 0;
    falls = 0;
    prev = exp_level;
    for (int i = 0; i < 12; i++) begin
      tick();
      rises += int'(sw_rise);
      falls += int'(sw_fall);
      checks++;
      if ((sw_rise & sw_fall) !== 1'b0 ||
          sw_rise !== (sw_clean === 1'b1 && prev === 1'b0) ||
          sw_fall !== (sw_clean === 1'b0 && prev === 1'b1)) begin
        errors++;
        $display("FAIL bounce_pulse cyc=%0d clean=%b prev=%b rise=%b fall=%b",
                 i, sw_clean, prev, sw_rise, sw_fall);
      end
      prev = sw_clean;
    end
    checks++;
    if (sw_clean !== final_level || rises != int'(final_level && !exp_level) ||
        falls != int'(!final_level && exp_level)) begin
      errors++;
      $display("FAIL bounce_settle clean=%b exp=%b rises=%0d falls=%0d",
               sw_clean, final_level, rises, falls);
    end
    exp_level = final_level;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_hold();
    test_fall();
    test_short_pulse();
    test_reset_mid();
    test_fall();
    test_hold();
    test_bounce(1'b1);
    test_bounce(1'b0);
    test_bounce(1'b0);
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
